seq_alu: RTL

Parametrised, multi-cycle successor to the single-cycle processor ALU. It generalises datapath width and adds iterative unsigned multiply, divide and remainder. Every operation is issued through a start/ready/done handshake, and results and flags are registered. It sits between the register file read ports and the writeback/flag logic; the control unit stalls issue while `ready` is low.

---
 rtl/seq_alu.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative MUL/DIV/REM (one bit per cycle).
// Single-cycle ops complete in 1 cycle, MUL/DIV/REM in W+1; start is ignored while not ready.
module seq_alu #(
  parameter int W   = 8,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [OPW-1:0] op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           carry_in,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   rslt,
  output logic           carry_out,
  output logic           zero,
  output logic           pari
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = $clog2(W) + 1;

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_AND = OPW'(2);
  localparam logic [OPW-1:0] OP_OR  = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4);
  localparam logic [OPW-1:0] OP_SHL = OPW'(5);
  localparam logic [OPW-1:0] OP_SHR = OPW'(6);
  localparam logic [OPW-1:0] OP_NOT = OPW'(7);
  localparam logic [OPW-1:0] OP_CMP = OPW'(8);
  localparam logic [OPW-1:0] OP_MOV = OPW'(9);
  localparam logic [OPW-1:0] OP_MUL = OPW'(10);
  localparam logic [OPW-1:0] OP_DIV = OPW'(11);
  localparam logic [OPW-1:0] OP_REM = OPW'(12);

  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(W);
  localparam logic [W:0]    W_VAL    = (W + 1)'(W);

  state_t         state;
  logic [OPW-1:0] op_q;
  logic [W-1:0]   a_q, b_q;
  logic [W-1:0]   hi, lo;
  logic [CW-1:0]  cnt;

  logic           accept, iter_op, res_load;
  logic [W:0]     sc_full, it_full, res_full;
  logic [W:0]     mul_sum, div_sh, div_diff;
  logic           div_ge;
  logic [W-1:0]   hi_nxt, lo_nxt;

  assign ready   = (state == IDLE) || (state == DONE);
  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign accept  = ready && start;
  assign iter_op = (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);

  // Single-cycle ops work straight off the issue inputs; bit W is carry_out.
  always_comb begin
    sc_full = '0;
    case (op)
      OP_ADD:         sc_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_in};
      OP_SUB, OP_CMP: sc_full = {1'b0, a} - {1'b0, b} + {{W{1'b0}}, carry_in};
      OP_AND:         sc_full = {1'b0, a & b};
      OP_OR:          sc_full = {1'b0, a | b};
      OP_XOR:         sc_full = {1'b0, a ^ b};
      OP_SHL:         sc_full = ({1'b0, a} >= W_VAL) ? '0 : {1'b0, b << a};
      OP_SHR:         sc_full = ({1'b0, a} >= W_VAL) ? '0 : {1'b0, b >> a};
      OP_NOT:         sc_full = {1'b0, ~a};
      OP_MOV:         sc_full = {1'b0, a};
      default:        sc_full = '0;
    endcase
  end

  // hi/lo hold {accumulator, multiplier} for MUL and {remainder, quotient} for DIV/REM.
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, a_q} : '0);
    div_sh   = {hi, lo[W-1]};
    div_ge   = div_sh >= {1'b0, b_q};
    div_diff = div_sh - {1'b0, b_q};
    if (op_q == OP_MUL) begin
      hi_nxt = mul_sum[W:1];
      lo_nxt = {mul_sum[0], lo[W-1:1]};
    end else begin
      hi_nxt = div_ge ? div_diff[W-1:0] : div_sh[W-1:0];
      lo_nxt = {lo[W-2:0], div_ge};
    end
    case (op_q)
      OP_MUL:  it_full = {|hi_nxt, lo_nxt};
      OP_DIV:  it_full = (b_q == '0) ? {1'b1, {W{1'b1}}} : {1'b0, lo_nxt};
      default: it_full = (b_q == '0) ? {1'b1, a_q} : {1'b0, hi_nxt};
    endcase
  end

  assign res_load = (accept && !iter_op) || ((state == RUN) && (cnt == CNT_LAST));
  assign res_full = (state == RUN) ? it_full : sc_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      rslt      <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      pari      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
            cnt  <= '0;
            if (iter_op) begin
              state <= RUN;
              hi    <= '0;
              lo    <= (op == OP_MUL) ? b : a;
            end else begin
              state <= DONE;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
          if (cnt == CNT_LAST) state <= DONE;
        end
        default: state <= IDLE;
      endcase
      if (res_load) begin
        rslt      <= res_full[W-1:0];
        carry_out <= res_full[W];
        zero      <= ~|res_full[W-1:0];
        pari      <= ^res_full[W-1:0];
      end
    end
  end

endmodule
